vga_timing_gen: RTL and testbench

- Parametrised VGA/raster timing generator. Successor to the fixed 640x480 sync counter.
- Derives a pixel tick from the system clock with an internal divider.
- Generates hsync/vsync with a configurable polarity, an active-video flag, pixel coordinates clamped to the active area, line/frame strobes and a frame counter.
- Feeds the renderer (sprite/tile fetch) and the VGA output pins.

---
 rtl/vga_timing_gen.sv | 130 +++++++++++++
 tb/tb_vga_timing_gen.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator: pixel-tick divider, h/v position counters
// and registered Moore decodes for sync, active video, coordinates and strobes.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int H_POL    = 0,
  parameter int V_POL    = 0,
  parameter int CLK_DIV  = 4,
  parameter int CW       = 11
) (
  input  logic          clk,
  input  logic          RSTN,
  input  logic          en,
  output logic          hsync,
  output logic          vsync,
  output logic          video_on,
  output logic [CW-1:0] pixel_x,
  output logic [CW-1:0] pixel_y,
  output logic          pix_tick,
  output logic          line_start,
  output logic          frame_start,
  output logic [15:0]   frame_count
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_ACT    = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_ACT    = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS_BEG   = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_END   = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] VS_BEG   = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_END   = CW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic          HP       = (H_POL != 0);
  localparam logic          VP       = (V_POL != 0);

  logic [DW-1:0] div;
  logic [CW-1:0] h;
  logic [CW-1:0] v;
  logic          started;

  logic tick_last;
  logic at_line;
  logic at_origin;
  logic in_active;
  logic in_hs;
  logic in_vs;

  always_comb begin
    tick_last = (div == DIV_LAST);
    at_line   = (div == '0) && (h == '0);
    at_origin = at_line && (v == '0);
    in_active = (h < H_ACT) && (v < V_ACT);
    in_hs     = (h >= HS_BEG) && (h < HS_END);
    in_vs     = (v >= VS_BEG) && (v < VS_END);
  end

  always_ff @(posedge clk or posedge RSTN) begin
    if (RSTN) begin
      div <= '0;
      h   <= '0;
      v   <= '0;
    end else if (!en) begin
      div <= '0;
      h   <= '0;
      v   <= '0;
    end else if (tick_last) begin
      div <= '0;
      if (h == H_LAST) begin
        h <= '0;
        v <= (v == V_LAST) ? '0 : v + 1'b1;
      end else begin
        h <= h + 1'b1;
      end
    end else begin
      div <= div + 1'b1;
    end
  end

  // started marks that the current run has already passed the origin once, so the
  // next origin visit closes a complete frame and bumps frame_count with frame_start.
  always_ff @(posedge clk or posedge RSTN) begin
    if (RSTN) begin
      hsync       <= ~HP;
      vsync       <= ~VP;
      video_on    <= 1'b0;
      pixel_x     <= '0;
      pixel_y     <= '0;
      pix_tick    <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      frame_count <= '0;
      started     <= 1'b0;
    end else if (!en) begin
      hsync       <= ~HP;
      vsync       <= ~VP;
      video_on    <= 1'b0;
      pixel_x     <= '0;
      pixel_y     <= '0;
      pix_tick    <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      started     <= 1'b0;
    end else begin
      hsync       <= in_hs ? HP : ~HP;
      vsync       <= in_vs ? VP : ~VP;
      video_on    <= in_active;
      pixel_x     <= in_active ? h : '0;
      pixel_y     <= in_active ? v : '0;
      pix_tick    <= (div == '0);
      line_start  <= at_line;
      frame_start <= at_origin;
      if (at_origin) begin
        started <= 1'b1;
        if (started) frame_count <= frame_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a small-parameter instance and a default-timing instance,
// each compared every clk against an arithmetic position model, plus directed timing checks.
module tb_vga_timing_gen;

  typedef struct packed {
    logic        hsync;
    logic        vsync;
    logic        video_on;
    logic [10:0] px;
    logic [10:0] py;
    logic        pix_tick;
    logic        line_start;
    logic        frame_start;
    logic [15:0] fc;
  } outs_t;

  logic clk = 1'b0;
  logic RSTN = 1'b1;
  logic en_s = 1'b1;
  logic en_b = 1'b1;

  logic        s_hsync, s_vsync, s_video_on, s_pix_tick, s_line_start, s_frame_start;
  logic [10:0] s_pixel_x, s_pixel_y;
  logic [15:0] s_frame_count;
  logic        b_hsync, b_vsync, b_video_on, b_pix_tick, b_line_start, b_frame_start;
  logic [10:0] b_pixel_x, b_pixel_y;
  logic [15:0] b_frame_count;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(1),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .H_POL(0), .V_POL(0), .CLK_DIV(2), .CW(11)
  ) u_small (
    .clk(clk), .RSTN(RSTN), .en(en_s),
    .hsync(s_hsync), .vsync(s_vsync), .video_on(s_video_on),
    .pixel_x(s_pixel_x), .pixel_y(s_pixel_y), .pix_tick(s_pix_tick),
    .line_start(s_line_start), .frame_start(s_frame_start), .frame_count(s_frame_count)
  );

  vga_timing_gen #(.H_POL(1), .CLK_DIV(1)) u_big (
    .clk(clk), .RSTN(RSTN), .en(en_b),
    .hsync(b_hsync), .vsync(b_vsync), .video_on(b_video_on),
    .pixel_x(b_pixel_x), .pixel_y(b_pixel_y), .pix_tick(b_pix_tick),
    .line_start(b_line_start), .frame_start(b_frame_start), .frame_count(b_frame_count)
  );

  // k = enabled clk edges since the last restart; the outputs after edge k show the
  // position reached after k-1 enabled clks.
  function automatic outs_t model(input int ha, hf, hsw, hb, va, vf, vsw, vb,
                                  input logic hp, vp, input int d, input int k,
                                  input logic [15:0] base);
    outs_t o;
    int n, dv, p, h, v, ht, vt, fr;
    ht = ha + hf + hsw + hb;
    vt = va + vf + vsw + vb;
    o = '0;
    o.hsync = !hp;
    o.vsync = !vp;
    o.fc = base;
    if (k > 0) begin
      n  = k - 1;
      dv = n % d;
      p  = n / d;
      h  = p % ht;
      v  = (p / ht) % vt;
      fr = p / (ht * vt);
      o.pix_tick    = (dv == 0);
      o.line_start  = (dv == 0) && (h == 0);
      o.frame_start = o.line_start && (v == 0);
      o.video_on    = (h < ha) && (v < va);
      if (o.video_on) begin
        o.px = 11'(h);
        o.py = 11'(v);
      end
      o.hsync = (h >= ha + hf && h < ha + hf + hsw) ? hp : !hp;
      o.vsync = (v >= va + vf && v < va + vf + vsw) ? vp : !vp;
      o.fc    = base + 16'(fr);
    end
    return o;
  endfunction

  function automatic outs_t exp_s(input int k, input logic [15:0] base);
    return model(8, 2, 3, 1, 4, 1, 2, 1, 1'b0, 1'b0, 2, k, base);
  endfunction

  function automatic outs_t exp_b(input int k, input logic [15:0] base);
    return model(640, 16, 96, 48, 480, 10, 2, 33, 1'b1, 1'b0, 1, k, base);
  endfunction

  int          k_s = 0, k_b = 0;
  logic [15:0] base_s = '0, base_b = '0;

  always @(posedge clk or posedge RSTN) begin
    if (RSTN) begin
      k_s = 0; base_s = '0;
      k_b = 0; base_b = '0;
    end else begin
      if (!en_s) begin
        base_s = exp_s(k_s, base_s).fc;
        k_s = 0;
      end else k_s++;
      if (!en_b) begin
        base_b = exp_b(k_b, base_b).fc;
        k_b = 0;
      end else k_b++;
    end
  end

  task automatic chk(input string name, input longint act, input longint exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  outs_t a_s, a_b;
  always_comb begin
    a_s = {s_hsync, s_vsync, s_video_on, s_pixel_x, s_pixel_y,
           s_pix_tick, s_line_start, s_frame_start, s_frame_count};
    a_b = {b_hsync, b_vsync, b_video_on, b_pixel_x, b_pixel_y,
           b_pix_tick, b_line_start, b_frame_start, b_frame_count};
  end

  always @(negedge clk) begin
    chk("small_model", longint'(a_s), longint'(exp_s(k_s, base_s)));
    chk("big_model", longint'(a_b), longint'(exp_b(k_b, base_b)));
  end

  initial begin
    int ls1, ls2, hs_first, hs_len, vid_len, vs_first, vs_len, nfs, npx;
    int fs_cyc[3];
    int fc_at[3];
    int px_seq[16];
    int bl2, bhs_first, bhs_len, bvid_len;
    int found;
    logic [15:0] held;

    // Reset levels
    repeat (3) @(negedge clk);
    chk("rst_s_hsync", s_hsync, 1);
    chk("rst_s_vsync", s_vsync, 1);
    chk("rst_s_video", s_video_on, 0);
    chk("rst_s_fc", s_frame_count, 0);
    chk("rst_b_hsync", b_hsync, 0);

    RSTN = 1'b0;
    ls1 = -1; ls2 = -1; hs_first = -1; hs_len = 0; vid_len = 0;
    vs_first = -1; vs_len = 0; nfs = 0; npx = 0;
    bl2 = -1; bhs_first = -1; bhs_len = 0; bvid_len = 0;
    for (int c = 0; c < 1700; c++) begin
      @(negedge clk);
      if (c == 0) begin
        chk("first_fs", s_frame_start, 1);
        chk("first_ls", s_line_start, 1);
        chk("first_tick", s_pix_tick, 1);
        chk("first_video", s_video_on, 1);
        chk("first_b_fs", b_frame_start, 1);
      end
      if (s_line_start) begin
        if (ls1 < 0) ls1 = c;
        else if (ls2 < 0) ls2 = c;
      end
      if (c < 28 && !s_hsync) begin
        if (hs_first < 0) hs_first = c;
        hs_len++;
      end
      if (c < 28 && s_video_on) vid_len++;
      if (c < 28 && s_pix_tick && npx < 16) begin
        px_seq[npx] = s_pixel_x;
        npx++;
      end
      if (c < 224 && !s_vsync) begin
        if (vs_first < 0) vs_first = c;
        vs_len++;
      end
      if (s_frame_start && nfs < 3) begin
        fs_cyc[nfs] = c;
        fc_at[nfs] = s_frame_count;
        nfs++;
      end
      if (c > 0 && b_line_start && bl2 < 0) bl2 = c;
      if (c < 800 && b_hsync) begin
        if (bhs_first < 0) bhs_first = c;
        bhs_len++;
      end
      if (c < 800 && b_video_on) bvid_len++;
    end
    chk("line_period", ls2 - ls1, 28);
    chk("hsync_offset", hs_first - ls1, 20);
    chk("hsync_width", hs_len, 6);
    chk("video_width", vid_len, 16);
    chk("px_count", npx, 14);
    for (int i = 0; i < 14; i++) chk("px_seq", px_seq[i], (i < 8) ? i : 0);
    chk("fs_count", nfs, 3);
    chk("frame_period1", fs_cyc[1] - fs_cyc[0], 224);
    chk("frame_period2", fs_cyc[2] - fs_cyc[1], 224);
    chk("vsync_offset", vs_first - fs_cyc[0], 140);
    chk("vsync_width", vs_len, 56);
    chk("fc0", fc_at[0], 0);
    chk("fc1", fc_at[1], 1);
    chk("fc2", fc_at[2], 2);
    chk("b_line_period", bl2, 800);
    chk("b_hsync_start", bhs_first, 656);
    chk("b_hsync_width", bhs_len, 96);
    chk("b_video_width", bvid_len, 640);

    // Mid-frame restart at (h=5, v=2)
    found = 0;
    for (int i = 0; i < 400 && !found; i++) begin
      @(negedge clk);
      if (s_video_on && s_pixel_x == 5 && s_pixel_y == 2) found = 1;
    end
    chk("restart_find", found, 1);
    held = exp_s(k_s, base_s).fc;
    en_s = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("restart_video", s_video_on, 0);
      chk("restart_tick", s_pix_tick, 0);
      chk("restart_hsync", s_hsync, 1);
      chk("restart_fc", s_frame_count, held);
    end
    en_s = 1'b1;
    @(negedge clk);
    chk("restart_fs", s_frame_start, 1);
    chk("restart_px", s_pixel_x, 0);

    // Randomised enable drops and reset pulses
    for (int it = 0; it < 40; it++) begin
      int r;
      repeat ($urandom_range(20, 500)) @(negedge clk);
      r = $urandom_range(0, 9);
      if (r < 6) begin
        en_s = 1'b0;
        repeat ($urandom_range(1, 6)) @(negedge clk);
        en_s = 1'b1;
      end else if (r < 8) begin
        en_b = 1'b0;
        repeat ($urandom_range(1, 6)) @(negedge clk);
        en_b = 1'b1;
      end else if (r == 8) begin
        @(posedge clk);
        #($urandom_range(1, 8));
        RSTN = 1'b1;
        @(negedge clk);
        RSTN = 1'b0;
      end
    end

    // Asynchronous reset between edges, mid-line
    repeat (300) @(negedge clk);
    @(posedge clk);
    #3;
    RSTN = 1'b1;
    #1;
    chk("async_fc", s_frame_count, 0);
    chk("async_video", s_video_on, 0);
    chk("async_hsync", s_hsync, 1);
    chk("async_b_hsync", b_hsync, 0);
    chk("async_tick", s_pix_tick, 0);
    @(negedge clk);
    RSTN = 1'b0;
    @(negedge clk);
    chk("async_release_fs", s_frame_start, 1);
    chk("async_release_b_fs", b_frame_start, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
